cc_line_fill_engine: RTL and testbench
======================================

CC_LINE_FILL_ENGINE -- requirements
Module: cc_line_fill_engine

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, miss address width; BEAT_W, default 64, AXI R beat width; LINE_W, default 512, cache line width; INDEX_W, default 9, SRAM index width.
REQ-002 SHALL derive BEATS=LINE_W/BEAT_W, OFF_W=log2(BEATS), BOFF_W=log2(BEAT_W/8), TAG_W=ADDR_W-INDEX_W-log2(LINE_W/8).
REQ-003 SHALL have ports: clk in 1, clock; rst_n in 1, reset, synchronous, active-low.
REQ-004 SHALL have ports: mem_rdata_i in BEAT_W, beat data; mem_rresp_i in 2, response; mem_rlast_i in 1, last beat; mem_rvalid_i in 1, beat valid; mem_rready_o out 1, beat accept.
REQ-005 SHALL have ports: miss_addr_fifo_empty_i in 1, FIFO empty; miss_addr_fifo_rdata_i in ADDR_W, head miss address (show-ahead); miss_addr_fifo_rden_o out 1, pop.
REQ-006 SHALL have ports: wren_o out 1, SRAM write; waddr_o out INDEX_W, line index; wdata_tag_o out TAG_W+1, {valid,tag}; wdata_data_o out LINE_W, line data.
REQ-007 SHALL have ports: crit_valid_o out 1, critical-word pulse; crit_data_o out BEAT_W, critical word; fill_err_o out 1, error pulse.

Function
REQ-008 SHALL implement FSM IDLE, FILL, WRITE; reset state IDLE.
REQ-009 IDLE: when miss_addr_fifo_empty_i=0, SHALL assert miss_addr_fifo_rden_o for exactly one cycle, latch index=addr[INDEX_W+log2(LINE_W/8)-1 -: INDEX_W], tag=addr[ADDR_W-1 -: TAG_W], offset=addr[BOFF_W +: OFF_W], clear beat counter and error flag, go FILL next cycle.
REQ-010 mem_rready_o SHALL be 1 only in FILL; beats presented in IDLE/WRITE SHALL stay unaccepted.
REQ-011 FILL: each handshake (rvalid&rready) SHALL store mem_rdata_i in line slot (offset+cnt) mod BEATS (OFF_W wrap-around) and increment cnt.
REQ-012 First handshake of a fill SHALL drive crit_valid_o=1 with crit_data_o=mem_rdata_i in the next cycle, one cycle only.
REQ-013 mem_rresp_i!=0 on any beat SHALL set sticky line error flag.
REQ-014 mem_rlast_i=1 with cnt!=BEATS-1, or mem_rlast_i=0 with cnt==BEATS-1, SHALL set the line error flag; fill length is counter-governed, never rlast-governed.
REQ-015 Handshake with cnt==BEATS-1 SHALL transition to WRITE.
REQ-016 WRITE: wren_o=1 for exactly one cycle with waddr_o=latched index, wdata_tag_o={~err,tag}, wdata_data_o=assembled line; fill_err_o=1 same cycle iff err; next state IDLE.
REQ-017 Latency: wren_o SHALL assert the cycle after the final beat handshake; new pop no earlier than the cycle after WRITE (back-to-back fills: BEATS+2 cycles per line min).
REQ-018 Gaps (rvalid=0) in FILL SHALL hold state, cnt and data.
REQ-019 waddr_o, wdata_tag_o, wdata_data_o SHALL be registered and stable whenever wren_o=1.

Reset
REQ-020 rst_n=0 SHALL force IDLE, cnt=0, err=0, and all outputs 0 (wdata_data_o, tag, addr included) on the next clk edge.
REQ-021 Reset mid-FILL or in WRITE SHALL abandon the line with no wren_o; popped address is lost.

Structure
REQ-022 Shared package cc_pkg SHALL hold the state enum and default parameter constants (ADDR_W, BEAT_W, LINE_W, INDEX_W).
REQ-023 Sub-module cc_fill_line_buffer SHALL hold the BEATS x BEAT_W slot register array with write enable, slot index and clear inputs.

Verification
REQ-024 Defaults, FIFO addr 0x0001_2358 (offset 3), 8 OKAY beats D0..D7, rlast on 8th -> slots 3,4,5,6,7,0,1,2 = D0..D7, waddr 0x08D, tag {1,0x00002}, crit_data D0, one wren, fill_err 0.
REQ-025 Offset 0, rvalid dropped 2 cycles after beat 4 -> line contiguous D0..D7, wren exactly one cycle after 8th handshake.
REQ-026 rresp=2'b10 on beat 5 -> wren with tag valid bit 0, fill_err_o pulse, next fill clean.
REQ-027 rlast on beat 6 -> error set, fill still consumes 8 beats, tag valid 0.
REQ-028 rst_n=0 after beat 3 -> no wren, all outputs 0, next FIFO entry fills correctly.
REQ-029 BEAT_W=128, LINE_W=512 -> 4-beat fill, offset addr[5:4] wrap correct.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and default geometry for the cache line-fill path.
// Pure declarations; no timing or flow-control behaviour of its own.
`timescale 1ns/1ps
package cc_pkg;
    localparam int CC_ADDR_W  = 32;
    localparam int CC_BEAT_W  = 64;
    localparam int CC_LINE_W  = 512;
    localparam int CC_INDEX_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } fill_state_e;
endpackage

// File: rtl/cc_fill_line_buffer.sv
// Slot register array that assembles one cache line from read beats.
// One-cycle write; no backpressure, the owner decides when a slot is written.
`timescale 1ns/1ps
module cc_fill_line_buffer #(
    parameter int BEATS  = 8,
    parameter int BEAT_W = 64,
    parameter int OFF_W  = 3
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    we,
    input  logic [OFF_W-1:0]        slot,
    input  logic [BEAT_W-1:0]       wdata,
    output logic [BEATS*BEAT_W-1:0] line
);
    logic [BEAT_W-1:0] slots [BEATS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < BEATS; i++) slots[i] <= '0;
        end else if (we) begin
            slots[slot] <= wdata;
        end
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
        assign line[gi*BEAT_W +: BEAT_W] = slots[gi];
    end
endmodule

// File: rtl/cc_line_fill_engine.sv
// Pops a miss address, gathers BEATS critical-word-first read beats into a line, writes tag+data SRAM.
// wren one cycle after the last beat; beats are only accepted in FILL, so the memory side stalls otherwise.
`timescale 1ns/1ps
module cc_line_fill_engine
    import cc_pkg::*;
#(
    parameter int ADDR_W  = CC_ADDR_W,
    parameter int BEAT_W  = CC_BEAT_W,
    parameter int LINE_W  = CC_LINE_W,
    parameter int INDEX_W = CC_INDEX_W
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [BEAT_W-1:0]                            mem_rdata_i,
    input  logic [1:0]                                   mem_rresp_i,
    input  logic                                         mem_rlast_i,
    input  logic                                         mem_rvalid_i,
    output logic                                         mem_rready_o,
    input  logic                                         miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]                            miss_addr_fifo_rdata_i,
    output logic                                         miss_addr_fifo_rden_o,
    output logic                                         wren_o,
    output logic [INDEX_W-1:0]                           waddr_o,
    output logic [ADDR_W-INDEX_W-$clog2(LINE_W/8):0]     wdata_tag_o,
    output logic [LINE_W-1:0]                            wdata_data_o,
    output logic                                         crit_valid_o,
    output logic [BEAT_W-1:0]                            crit_data_o,
    output logic                                         fill_err_o
);
    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int OFF_W   = $clog2(BEATS);
    localparam int BOFF_W  = $clog2(BEAT_W / 8);
    localparam int LBYTE_W = $clog2(LINE_W / 8);
    localparam int TAG_W   = ADDR_W - INDEX_W - LBYTE_W;

    fill_state_e       state_q, state_d;
    logic [OFF_W-1:0]  cnt_q;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W-1:0]  slot;
    logic [TAG_W-1:0]  tag_q;
    logic              err_q;
    logic              hs;
    logic              last_beat;
    logic              beat_err;
    logic              unused_addr_bits;

    assign hs        = mem_rvalid_i & mem_rready_o;
    assign last_beat = (cnt_q == OFF_W'(BEATS - 1));
    // Framing error: rlast disagrees with the counter, which alone decides line length.
    assign beat_err  = (mem_rresp_i != 2'b00) || (mem_rlast_i != last_beat);
    assign slot      = off_q + cnt_q;
    assign unused_addr_bits = ^miss_addr_fifo_rdata_i[BOFF_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d               = state_q;
        mem_rready_o          = 1'b0;
        miss_addr_fifo_rden_o = 1'b0;
        wren_o                = 1'b0;
        fill_err_o            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!miss_addr_fifo_empty_i && rst_n) begin
                    miss_addr_fifo_rden_o = 1'b1;
                    state_d               = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_rready_o = 1'b1;
                if (mem_rvalid_i && last_beat) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wren_o     = 1'b1;
                fill_err_o = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            off_q        <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            waddr_o      <= '0;
            wdata_tag_o  <= '0;
            crit_valid_o <= 1'b0;
            crit_data_o  <= '0;
        end else begin
            crit_valid_o <= 1'b0;
            if (miss_addr_fifo_rden_o) begin
                waddr_o <= miss_addr_fifo_rdata_i[INDEX_W+LBYTE_W-1 -: INDEX_W];
                tag_q   <= miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W];
                off_q   <= miss_addr_fifo_rdata_i[BOFF_W +: OFF_W];
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end
            if (hs) begin
                cnt_q <= cnt_q + 1'b1;
                if (beat_err) err_q <= 1'b1;
                if (cnt_q == '0) begin
                    crit_valid_o <= 1'b1;
                    crit_data_o  <= mem_rdata_i;
                end
                // Tag is captured with the final beat so it already reflects that beat's error.
                if (last_beat) wdata_tag_o <= {~(err_q | beat_err), tag_q};
            end
        end
    end

    cc_fill_line_buffer #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .OFF_W  (OFF_W)
    ) u_line_buf (
        .clk    (clk),
        .clr    (~rst_n),
        .we     (hs),
        .slot   (slot),
        .wdata  (mem_rdata_i),
        .line   (wdata_data_o)
    );
endmodule

// File: tb/tb_cc_line_fill_engine.sv
// Scoreboard bench for the line-fill engine: default 64-bit beats plus a 128-bit beat instance.
`timescale 1ns/1ps
module tb_cc_line_fill_engine;
    import cc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic         fifo_empty;
    logic [31:0]  fifo_rdata;
    logic         fifo_rden;
    logic         wren;
    logic [8:0]   waddr;
    logic [17:0]  wtag;
    logic [511:0] wdata;
    logic         crit_v;
    logic [63:0]  crit_d;
    logic         fill_err;

    logic [31:0] fifo_mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = fifo_mem[rd_ptr % 32];
    always @(posedge clk) if (fifo_rden) rd_ptr <= rd_ptr + 1;

    cc_line_fill_engine u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_rdata_i            (rdata),
        .mem_rresp_i            (rresp),
        .mem_rlast_i            (rlast),
        .mem_rvalid_i           (rvalid),
        .mem_rready_o           (rready),
        .miss_addr_fifo_empty_i (fifo_empty),
        .miss_addr_fifo_rdata_i (fifo_rdata),
        .miss_addr_fifo_rden_o  (fifo_rden),
        .wren_o                 (wren),
        .waddr_o                (waddr),
        .wdata_tag_o            (wtag),
        .wdata_data_o           (wdata),
        .crit_valid_o           (crit_v),
        .crit_data_o            (crit_d),
        .fill_err_o             (fill_err)
    );

    // 128-bit beat instance
    logic [127:0] w_rdata = '0;
    logic [1:0]   w_rresp = '0;
    logic         w_rlast = 1'b0;
    logic         w_rvalid = 1'b0;
    logic         w_rready;
    logic         w_empty = 1'b1;
    logic [31:0]  w_addr = '0;
    logic         w_rden;
    logic         w_wren;
    logic [8:0]   w_waddr;
    logic [17:0]  w_wtag;
    logic [511:0] w_wdata;
    logic         w_crit_v;
    logic [127:0] w_crit_d;
    logic         w_fill_err;

    cc_line_fill_engine #(.BEAT_W(128)) u_dut_wide (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_rdata_i            (w_rdata),
        .mem_rresp_i            (w_rresp),
        .mem_rlast_i            (w_rlast),
        .mem_rvalid_i           (w_rvalid),
        .mem_rready_o           (w_rready),
        .miss_addr_fifo_empty_i (w_empty),
        .miss_addr_fifo_rdata_i (w_addr),
        .miss_addr_fifo_rden_o  (w_rden),
        .wren_o                 (w_wren),
        .waddr_o                (w_waddr),
        .wdata_tag_o            (w_wtag),
        .wdata_data_o           (w_wdata),
        .crit_valid_o           (w_crit_v),
        .crit_data_o            (w_crit_d),
        .fill_err_o             (w_fill_err)
    );

    typedef struct {
        logic [8:0]   idx;
        logic [17:0]  tag;
        logic [511:0] data;
        logic         err;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    logic [63:0] crit_q[$];
    wr_exp_t     sb_e;
    logic [63:0] sb_c;
    int wren_seen = 0;
    int crit_seen = 0;
    int rden_seen = 0;
    int wren_last = 0;
    int wren_prev = 0;

    always @(negedge clk) begin
        if (fifo_rden) rden_seen++;
        if (wren) begin
            wren_prev = wren_last;
            wren_last = cyc;
            wren_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write unexpected wren waddr=%h tag=%h", waddr, wtag);
            end else begin
                sb_e = exp_q.pop_front();
                if (waddr !== sb_e.idx || wtag !== sb_e.tag || wdata !== sb_e.data || fill_err !== sb_e.err) begin
                    errors++;
                    $display("FAIL sb_write got waddr=%h tag=%h err=%b data=%h want waddr=%h tag=%h err=%b data=%h",
                             waddr, wtag, fill_err, wdata, sb_e.idx, sb_e.tag, sb_e.err, sb_e.data);
                end
            end
        end
        if (crit_v) begin
            crit_seen++;
            checks++;
            if (crit_q.size() == 0) begin
                errors++;
                $display("FAIL sb_crit unexpected crit_valid data=%h", crit_d);
            end else begin
                sb_c = crit_q.pop_front();
                if (crit_d !== sb_c) begin
                    errors++;
                    $display("FAIL sb_crit got %h want %h", crit_d, sb_c);
                end
            end
        end
    end

    // Drives one fill on the default instance and pushes the model's expected write.
    task automatic drive_fill(input logic [31:0] addr, input int n_hs, input int rlast_at,
                              input int err_at, input int gap_after, input int gap_len,
                              input bit push_exp, output int last_cyc);
        logic [63:0]  d [8];
        logic [511:0] line;
        wr_exp_t      e;
        int off, b, gap_rem, guard;
        bit err;
        off  = int'((addr >> 3) & 32'h7);
        line = '0;
        err  = (err_at >= 0) || (rlast_at != 7);
        for (int i = 0; i < 8; i++) begin
            d[i] = {$urandom, $urandom};
            line[((off + i) % 8) * 64 +: 64] = d[i];
        end
        e.idx  = addr[14:6];
        e.tag  = {~err, addr[31:15]};
        e.data = line;
        e.err  = err;
        if (push_exp) exp_q.push_back(e);
        fifo_mem[wr_ptr % 32] = addr;
        wr_ptr++;
        b = 0; gap_rem = 0; guard = 0; last_cyc = 0;
        while (b < n_hs && guard < 500) begin
            @(negedge clk);
            guard++;
            if (gap_rem > 0) begin
                rvalid = 1'b0;
                gap_rem--;
            end else begin
                rvalid = 1'b1;
                rdata  = d[b];
                rresp  = (b == err_at) ? 2'b10 : 2'b00;
                rlast  = (b == rlast_at);
            end
            if (rvalid && rready) begin
                if (b == 0) crit_q.push_back(d[0]);
                last_cyc = cyc;
                b++;
                if (b == gap_after) gap_rem = gap_len;
            end
        end
        checks++;
        if (b != n_hs) begin
            errors++;
            $display("FAIL fill_timeout accepted %0d beats want %0d", b, n_hs);
        end
    endtask

    task automatic release_r();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rvalid = 1'b1;
        rdata  = 64'hDEAD_BEEF_0000_0001;
        repeat (3) @(negedge clk);
        checks += 9;
        if (rready !== 1'b0)   begin errors++; $display("FAIL rst_rready got %b want 0", rready); end
        if (fifo_rden !== 1'b0) begin errors++; $display("FAIL rst_rden got %b want 0", fifo_rden); end
        if (wren !== 1'b0)     begin errors++; $display("FAIL rst_wren got %b want 0", wren); end
        if (waddr !== '0)      begin errors++; $display("FAIL rst_waddr got %h want 0", waddr); end
        if (wtag !== '0)       begin errors++; $display("FAIL rst_wtag got %h want 0", wtag); end
        if (wdata !== '0)      begin errors++; $display("FAIL rst_wdata got %h want 0", wdata); end
        if (crit_v !== 1'b0)   begin errors++; $display("FAIL rst_crit_valid got %b want 0", crit_v); end
        if (crit_d !== '0)     begin errors++; $display("FAIL rst_crit_data got %h want 0", crit_d); end
        if (fill_err !== 1'b0) begin errors++; $display("FAIL rst_fill_err got %b want 0", fill_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rready !== 1'b0) begin errors++; $display("FAIL idle_rready got %b want 0", rready); end
        release_r();
    endtask

    task automatic test_basic();
        int lc, w0, r0, c0;
        w0 = wren_seen; r0 = rden_seen; c0 = crit_seen;
        drive_fill(32'h0001_2358, 8, 7, -1, -1, 0, 1'b1, lc);
        @(negedge clk);
        release_r();
        checks += 3;
        if (wren !== 1'b1 || cyc != lc + 1) begin errors++; $display("FAIL basic_latency wren=%b cyc=%0d want wren=1 cyc=%0d", wren, cyc, lc + 1); end
        if (waddr !== 9'h08D) begin errors++; $display("FAIL basic_waddr got %h want 08d", waddr); end
        if (wtag !== 18'h2_0002) begin errors++; $display("FAIL basic_tag got %h want 20002", wtag); end
        @(negedge clk);
        checks += 4;
        if (wren !== 1'b0) begin errors++; $display("FAIL basic_wren_width got %b want 0", wren); end
        if (wren_seen - w0 != 1) begin errors++; $display("FAIL basic_wren_count got %0d want 1", wren_seen - w0); end
        if (rden_seen - r0 != 1) begin errors++; $display("FAIL basic_pop_count got %0d want 1", rden_seen - r0); end
        if (crit_seen - c0 != 1) begin errors++; $display("FAIL basic_crit_count got %0d want 1", crit_seen - c0); end
    endtask

    task automatic test_gap();
        int lc;
        drive_fill(32'h0004_0040, 8, 7, -1, 4, 2, 1'b1, lc);
        @(negedge clk);
        release_r();
        checks++;
        if (wren !== 1'b1 || cyc != lc + 1) begin errors++; $display("FAIL gap_latency wren=%b cyc=%0d want wren=1 cyc=%0d", wren, cyc, lc + 1); end
        @(negedge clk);
    endtask

    task automatic test_resp_err();
        int lc;
        drive_fill(32'h0010_0A08, 8, 7, 4, -1, 0, 1'b1, lc);
        @(negedge clk);
        release_r();
        checks += 2;
        if (fill_err !== 1'b1 || wren !== 1'b1) begin errors++; $display("FAIL resp_err_pulse fill_err=%b wren=%b want 1 1", fill_err, wren); end
        if (wtag[17] !== 1'b0) begin errors++; $display("FAIL resp_err_valid got %b want 0", wtag[17]); end
        @(negedge clk);
        checks++;
        if (fill_err !== 1'b0) begin errors++; $display("FAIL resp_err_width got %b want 0", fill_err); end
        drive_fill(32'h0020_3F30, 8, 7, -1, -1, 0, 1'b1, lc);
        @(negedge clk);
        release_r();
        checks++;
        if (fill_err !== 1'b0 || wtag[17] !== 1'b1) begin errors++; $display("FAIL resp_err_clean fill_err=%b valid=%b want 0 1", fill_err, wtag[17]); end
        @(negedge clk);
    endtask

    task automatic test_rlast_err();
        int lc, w0;
        w0 = wren_seen;
        drive_fill(32'h8000_1110, 8, 5, -1, -1, 0, 1'b1, lc);
        @(negedge clk);
        release_r();
        checks += 2;
        if (wren !== 1'b1 || cyc != lc + 1) begin errors++; $display("FAIL rlast_latency wren=%b cyc=%0d want wren=1 cyc=%0d", wren, cyc, lc + 1); end
        if (wtag[17] !== 1'b0) begin errors++; $display("FAIL rlast_valid got %b want 0", wtag[17]); end
        @(negedge clk);
        checks++;
        if (wren_seen - w0 != 1) begin errors++; $display("FAIL rlast_wren_count got %0d want 1", wren_seen - w0); end
    endtask

    task automatic test_reset_mid();
        int lc, w0;
        w0 = wren_seen;
        drive_fill(32'h0003_4568, 3, 7, -1, -1, 0, 1'b0, lc);
        @(negedge clk);
        release_r();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 4;
        if (rready !== 1'b0) begin errors++; $display("FAIL midrst_rready got %b want 0", rready); end
        if (waddr !== '0)    begin errors++; $display("FAIL midrst_waddr got %h want 0", waddr); end
        if (wtag !== '0)     begin errors++; $display("FAIL midrst_wtag got %h want 0", wtag); end
        if (wdata !== '0)    begin errors++; $display("FAIL midrst_wdata got %h want 0", wdata); end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (wren_seen != w0) begin errors++; $display("FAIL midrst_no_write got %0d writes want 0", wren_seen - w0); end
        drive_fill(32'h00FF_FFF8, 8, 7, -1, -1, 0, 1'b1, lc);
        @(negedge clk);
        release_r();
        checks++;
        if (wren !== 1'b1) begin errors++; $display("FAIL midrst_refill wren=%b want 1", wren); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lc1, lc2;
        drive_fill(32'h0000_0018, 8, 7, -1, -1, 0, 1'b1, lc1);
        drive_fill(32'h1234_5678, 8, 7, -1, -1, 0, 1'b1, lc2);
        @(negedge clk);
        release_r();
        checks += 2;
        if (wren !== 1'b1) begin errors++; $display("FAIL b2b_wren got %b want 1", wren); end
        if (wren_last - wren_prev != 10) begin errors++; $display("FAIL b2b_spacing got %0d want 10", wren_last - wren_prev); end
        @(negedge clk);
    endtask

    task automatic test_wide();
        logic [127:0] d [4];
        logic [511:0] line;
        wr_exp_t      wq[$];
        wr_exp_t      e;
        logic [31:0]  addr;
        int off, b, guard;
        addr = 32'h0000_ABE0;
        off  = int'((addr >> 4) & 32'h3);
        line = '0;
        for (int i = 0; i < 4; i++) begin
            d[i] = {$urandom, $urandom, $urandom, $urandom};
            line[((off + i) % 4) * 128 +: 128] = d[i];
        end
        e.idx = addr[14:6]; e.tag = {1'b1, addr[31:15]}; e.data = line; e.err = 1'b0;
        wq.push_back(e);
        w_addr = addr;
        w_empty = 1'b0;
        b = 0; guard = 0;
        while (b < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (w_rden) w_empty = 1'b1;
            if (b == 1) begin
                checks++;
                if (w_crit_v !== 1'b1 || w_crit_d !== d[0]) begin errors++; $display("FAIL wide_crit valid=%b data=%h want 1 %h", w_crit_v, w_crit_d, d[0]); end
            end
            w_rvalid = 1'b1;
            w_rdata  = d[b];
            w_rlast  = (b == 3);
            if (w_rready) b++;
        end
        @(negedge clk);
        w_rvalid = 1'b0;
        w_rlast  = 1'b0;
        checks++;
        if (w_wren !== 1'b1 || wq.size() == 0) begin
            errors++;
            $display("FAIL wide_wren got %b want 1 (beats %0d)", w_wren, b);
        end else begin
            e = wq.pop_front();
            checks += 3;
            if (w_waddr !== e.idx) begin errors++; $display("FAIL wide_waddr got %h want %h", w_waddr, e.idx); end
            if (w_wtag !== e.tag || w_fill_err !== e.err) begin errors++; $display("FAIL wide_tag got %h err=%b want %h err=%b", w_wtag, w_fill_err, e.tag, e.err); end
            if (w_wdata !== e.data) begin errors++; $display("FAIL wide_data got %h want %h", w_wdata, e.data); end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_resp_err();
        test_rlast_err();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || crit_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending writes=%0d crits=%0d want 0 0", exp_q.size(), crit_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
